// File: rtl/bus_arbiter_pkg.sv
// Arbiter state, owner encoding and grant decode shared by
// the arbiter top and its tie-break selector.
package bus_arbiter_pkg;

    import Types_pkg::*;

    localparam int STRB_W  = 4;
    localparam int GRANT_W = 2;

    typedef logic [STRB_W-1:0]  strb_t;
    typedef logic [GRANT_W-1:0] grant_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } owner_t;

    function automatic grant_t grant_of(input state_t s);
        grant_t g;
        g = '0;
        case (s)
            OWN0:    g = 2'b01;
            OWN1:    g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    function automatic state_t own_state(input owner_t o);
        return (o == OWNER_M0) ? OWN0 : OWN1;
    endfunction

endpackage

// File: rtl/types_pkg.sv
// Common data types shared across the bus fabric.
package Types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/bus_arbiter_rr_select.sv
// Picks the winner among two requesters; on a tie it alternates
// against last_owner in round-robin mode, else favours m0.
module rr_select
    import bus_arbiter_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  owner_t last_owner,
    input  logic   mode,
    output owner_t winner
);

    logic tie;

    assign tie = req0 && req1;

    always_comb begin
        winner = OWNER_M0;
        if (tie) begin
            if (mode && (last_owner == OWNER_M0)) begin
                winner = OWNER_M1;
            end else begin
                winner = OWNER_M0;
            end
        end else if (req1) begin
            winner = OWNER_M1;
        end else begin
            winner = OWNER_M0;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master to one-slave bus arbiter with registered ownership,
// direct owner hand-off on completion and abort on dropped valid.
module bus_arbiter
    import Types_pkg::*;
    import bus_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic   clk,
    input  logic   reset,

    input  logic   m0_valid,
    input  word_t  m0_address,
    input  strb_t  m0_wstrobe,
    input  word_t  m0_wdata,
    output logic   m0_ready,
    output word_t  m0_rdata,

    input  logic   m1_valid,
    input  word_t  m1_address,
    input  strb_t  m1_wstrobe,
    input  word_t  m1_wdata,
    output logic   m1_ready,
    output word_t  m1_rdata,

    output logic   s_valid,
    output word_t  s_address,
    output strb_t  s_wstrobe,
    output word_t  s_wdata,
    input  logic   s_ready,
    input  word_t  s_rdata,

    output grant_t grant
);

    localparam logic RR_MODE = (ROUND_ROBIN != 0);

    state_t state;
    owner_t last_owner;
    owner_t winner;

    rr_select u_rr_select (
        .req0       (m0_valid),
        .req1       (m1_valid),
        .last_owner (last_owner),
        .mode       (RR_MODE),
        .winner     (winner)
    );

    // Owner drops valid -> abort; owner valid with s_ready -> complete.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_owner <= OWNER_M1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        state <= own_state(winner);
                    end
                end
                OWN0: begin
                    if (!m0_valid) begin
                        state <= IDLE;
                    end else if (s_ready) begin
                        last_owner <= OWNER_M0;
                        state      <= m1_valid ? OWN1 : IDLE;
                    end
                end
                OWN1: begin
                    if (!m1_valid) begin
                        state <= IDLE;
                    end else if (s_ready) begin
                        last_owner <= OWNER_M1;
                        state      <= m0_valid ? OWN0 : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        s_valid   = 1'b0;
        s_address = '0;
        s_wstrobe = '0;
        s_wdata   = '0;
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        case (state)
            OWN0: begin
                s_valid   = m0_valid;
                s_address = m0_address;
                s_wstrobe = m0_wstrobe;
                s_wdata   = m0_wdata;
                m0_ready  = s_ready;
            end
            OWN1: begin
                s_valid   = m1_valid;
                s_address = m1_address;
                s_wstrobe = m1_wstrobe;
                s_wdata   = m1_wdata;
                m1_ready  = s_ready;
            end
            default: begin
                s_valid = 1'b0;
            end
        endcase
    end

    assign grant    = grant_of(state);
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: round-robin and fixed-priority
// instances share stimulus; each scenario starts from reset.
module tb_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_valid, m1_valid, s_ready;
    logic [31:0] m0_address, m1_address, m0_wdata, m1_wdata, s_rdata;
    logic [3:0]  m0_wstrobe, m1_wstrobe;

    logic        rr_m0_ready, rr_m1_ready, rr_s_valid;
    logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_s_address, rr_s_wdata;
    logic [3:0]  rr_s_wstrobe;
    logic [1:0]  rr_grant;

    logic        fp_m0_ready, fp_m1_ready, fp_s_valid;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_address, fp_s_wdata;
    logic [3:0]  fp_s_wstrobe;
    logic [1:0]  fp_grant;

    int passed = 0;
    int total  = 0;

    bus_arbiter #(.ROUND_ROBIN(1)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_address(m0_address),
        .m0_wstrobe(m0_wstrobe), .m0_wdata(m0_wdata),
        .m0_ready(rr_m0_ready), .m0_rdata(rr_m0_rdata),
        .m1_valid(m1_valid), .m1_address(m1_address),
        .m1_wstrobe(m1_wstrobe), .m1_wdata(m1_wdata),
        .m1_ready(rr_m1_ready), .m1_rdata(rr_m1_rdata),
        .s_valid(rr_s_valid), .s_address(rr_s_address),
        .s_wstrobe(rr_s_wstrobe), .s_wdata(rr_s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(rr_grant)
    );

    bus_arbiter #(.ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_address(m0_address),
        .m0_wstrobe(m0_wstrobe), .m0_wdata(m0_wdata),
        .m0_ready(fp_m0_ready), .m0_rdata(fp_m0_rdata),
        .m1_valid(m1_valid), .m1_address(m1_address),
        .m1_wstrobe(m1_wstrobe), .m1_wdata(m1_wdata),
        .m1_ready(fp_m1_ready), .m1_rdata(fp_m1_rdata),
        .s_valid(fp_s_valid), .s_address(fp_s_address),
        .s_wstrobe(fp_s_wstrobe), .s_wdata(fp_s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(fp_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        m0_valid = 0; m1_valid = 0; s_ready = 0;
        m0_address = '0; m1_address = '0;
        m0_wdata = '0; m1_wdata = '0;
        m0_wstrobe = '0; m1_wstrobe = '0;
        s_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    logic [1:0] exp_seq [6];

    initial begin
        reset = 1'b1;
        clear_inputs();
        #3;

        // Reset state
        reset = 1'b0;
        #1;
        check("rst_grant", rr_grant, 2'b00);
        check("rst_svalid", rr_s_valid, 1'b0);
        check("rst_m0_ready", rr_m0_ready, 1'b0);
        check("rst_m1_ready", rr_m1_ready, 1'b0);
        step();
        reset = 1'b1;

        // Single m0 read
        m0_valid = 1; m0_address = 32'h100; m0_wstrobe = 4'h0;
        #1;
        check("s1_no_comb_svalid", rr_s_valid, 1'b0);
        check("s1_no_comb_grant", rr_grant, 2'b00);
        step();
        check("s1_grant", rr_grant, 2'b01);
        check("s1_svalid", rr_s_valid, 1'b1);
        check("s1_saddr", rr_s_address, 32'h100);
        check("s1_wait_ready", rr_m0_ready, 1'b0);
        step();
        check("s1_hold_grant", rr_grant, 2'b01);
        s_ready = 1; s_rdata = 32'hDEADBEEF;
        #1;
        check("s1_m0_ready", rr_m0_ready, 1'b1);
        check("s1_m0_rdata", rr_m0_rdata, 32'hDEADBEEF);
        check("s1_m1_ready", rr_m1_ready, 1'b0);
        step();
        m0_valid = 0; s_ready = 0;
        #1;
        check("s1_idle_grant", rr_grant, 2'b00);
        check("s1_idle_svalid", rr_s_valid, 1'b0);
        check("s1_idle_saddr", rr_s_address, 32'h0);
        check("s1_idle_ready", rr_m0_ready, 1'b0);

        // Tie after reset, direct switch to m1 write
        do_reset();
        m0_valid = 1; m0_address = 32'h40;
        m1_valid = 1; m1_address = 32'h200;
        m1_wstrobe = 4'hF; m1_wdata = 32'hCAFEF00D;
        step();
        check("s2_first_owner", rr_grant, 2'b01);
        check("s2_m0_wstrobe", rr_s_wstrobe, 4'h0);
        s_ready = 1;
        #1;
        check("s2_m0_ready", rr_m0_ready, 1'b1);
        step();
        m0_valid = 0;
        #1;
        check("s2_switch", rr_grant, 2'b10);
        check("s2_swdata", rr_s_wdata, 32'hCAFEF00D);
        check("s2_swstrobe", rr_s_wstrobe, 4'hF);
        check("s2_saddr", rr_s_address, 32'h200);
        check("s2_m1_ready", rr_m1_ready, 1'b1);
        check("s2_m0_not_ready", rr_m0_ready, 1'b0);
        step();
        m1_valid = 0; s_ready = 0;
        #1;
        check("s2_idle", rr_grant, 2'b00);

        // Fairness with continuous requests
        do_reset();
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        m0_valid = 1; m1_valid = 1; s_ready = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("s3_owner%0d", i), rr_grant, exp_seq[i]);
        end
        clear_inputs();
        step();

        // Fixed priority: three back-to-back transfers
        do_reset();
        m0_valid = 1; m1_valid = 1; s_ready = 1;
        step();
        check("s4_fp_t0", fp_grant, 2'b01);
        step();
        check("s4_fp_t1", fp_grant, 2'b10);
        step();
        check("s4_fp_t2", fp_grant, 2'b01);
        clear_inputs();
        step();

        // Tie from IDLE after m0 served: modes diverge
        do_reset();
        m0_valid = 1; s_ready = 1;
        step();
        check("s4_pre_rr", rr_grant, 2'b01);
        check("s4_pre_fp", fp_grant, 2'b01);
        step();
        m0_valid = 0; s_ready = 0;
        #1;
        check("s4_idle_fp", fp_grant, 2'b00);
        m0_valid = 1; m1_valid = 1;
        step();
        check("s4_tie_rr", rr_grant, 2'b10);
        check("s4_tie_fp", fp_grant, 2'b01);
        clear_inputs();
        step();
        step();

        // Abort by m1 leaves last_owner at m0
        do_reset();
        m0_valid = 1; s_ready = 1;
        step();
        check("s5_m0_own", rr_grant, 2'b01);
        step();
        m0_valid = 0; s_ready = 0;
        m1_valid = 1;
        #1;
        check("s5_idle_ignore_sready", rr_grant, 2'b00);
        step();
        check("s5_m1_own", rr_grant, 2'b10);
        m1_valid = 0;
        #1;
        check("s5_no_m1_ready", rr_m1_ready, 1'b0);
        step();
        check("s5_abort_idle", rr_grant, 2'b00);
        check("s5_abort_svalid", rr_s_valid, 1'b0);
        m0_valid = 1; m1_valid = 1;
        step();
        check("s5_tie_after_abort", rr_grant, 2'b10);
        clear_inputs();
        step();
        step();

        // Mid-transfer asynchronous reset
        do_reset();
        m0_valid = 1; m0_address = 32'h300;
        step();
        check("s6_owned", rr_grant, 2'b01);
        check("s6_svalid", rr_s_valid, 1'b1);
        #1;
        reset = 1'b0;
        s_ready = 1;
        #1;
        check("s6_async_svalid", rr_s_valid, 1'b0);
        check("s6_async_grant", rr_grant, 2'b00);
        check("s6_async_ready", rr_m0_ready, 1'b0);
        step();
        check("s6_held_grant", rr_grant, 2'b00);
        s_ready = 0;
        #3;
        reset = 1'b1;
        step();
        check("s6_regrant", rr_grant, 2'b01);
        check("s6_regrant_addr", rr_s_address, 32'h300);
        clear_inputs();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
